// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects (registered one cycle ahead from ID addresses)
// plus load-use hazard detection with a configurable bubble count and event counters.
module fwd_hazard_unit #(
    parameter int ADDR_W      = 5,
    parameter int LOAD_STALL  = 1,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_id,
    input  logic [ADDR_W-1:0] rt_id,
    input  logic              rt_used_id,
    input  logic [ADDR_W-1:0] wr_addr_ex,
    input  logic              wr_en_ex,
    input  logic              mem_read_ex,
    input  logic [ADDR_W-1:0] wr_addr_mem,
    input  logic              wr_en_mem,
    input  logic              flush,
    output logic [1:0]        upper_sel,
    output logic [1:0]        lower_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  fwd_count,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] REM_LOAD = 2'(LOAD_STALL - 1);

    function automatic logic match(input logic en, input logic [ADDR_W-1:0] w,
                                   input logic [ADDR_W-1:0] a);
        return en && (w == a) && !((ZERO_REG_EN != 0) && (a == '0));
    endfunction

    logic [ADDR_W-1:0] src [2];
    logic [1:0]        src_used;
    logic [1:0]        ex_hit;
    logic [1:0]        mem_hit;
    logic [1:0]        sel_next [2];
    logic [1:0]        sel_reg  [2];
    logic [1:0]        rem_reg;
    logic [1:0]        rem_next;
    logic              det;
    logic              any_fwd;
    logic [CNT_W-1:0]  fwd_count_reg;
    logic [CNT_W-1:0]  stall_count_reg;

    assign src[0]   = rs_id;
    assign src[1]   = rt_id;
    assign src_used = {rt_used_id, 1'b1};

    // Lane 0 drives the rs (upper) mux, lane 1 the rt (lower) mux.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign ex_hit[gi]  = src_used[gi] && match(wr_en_ex, wr_addr_ex, src[gi]);
            assign mem_hit[gi] = src_used[gi] && match(wr_en_mem, wr_addr_mem, src[gi]);

            always_comb begin
                sel_next[gi] = 2'd0;
                if (flush || stall)
                    sel_next[gi] = 2'd0;
                else if (ex_hit[gi] && !mem_read_ex)
                    sel_next[gi] = 2'd2;
                else if (mem_hit[gi])
                    sel_next[gi] = 2'd1;
            end

            always_ff @(posedge clk) begin
                if (!rst_n)
                    sel_reg[gi] <= 2'd0;
                else
                    sel_reg[gi] <= sel_next[gi];
            end
        end
    endgenerate

    assign det     = (rem_reg == 2'd0) && !flush && mem_read_ex && (|ex_hit);
    // A flush squashes the dependent instruction, so it also kills any pending bubble.
    assign stall   = !flush && (det || (rem_reg != 2'd0));
    assign any_fwd = (sel_next[0] != 2'd0) || (sel_next[1] != 2'd0);

    always_comb begin
        rem_next = rem_reg;
        if (flush)
            rem_next = 2'd0;
        else if (det)
            rem_next = REM_LOAD;
        else if (rem_reg != 2'd0)
            rem_next = rem_reg - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_reg         <= 2'd0;
            fwd_count_reg   <= '0;
            stall_count_reg <= '0;
        end else begin
            rem_reg <= rem_next;
            if (any_fwd && (fwd_count_reg != '1))
                fwd_count_reg <= fwd_count_reg + 1'b1;
            if (stall && (stall_count_reg != '1))
                stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign upper_sel   = sel_reg[0];
    assign lower_sel   = sel_reg[1];
    assign fwd_count   = fwd_count_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: three parameterisations share one stimulus stream; a small
// reference model predicts stall (same cycle) and selects/counters (after the edge).
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n, flush, rt_used_id, wr_en_ex, mem_read_ex, wr_en_mem;
    logic [4:0] rs_id, rt_id, wr_addr_ex, wr_addr_mem;

    logic [1:0]  up_o [3];
    logic [1:0]  lo_o [3];
    logic        st_o [3];
    logic [3:0]  fc0, sc0;
    logic [15:0] fc1, sc1, fc2, sc2;

    always #5 clk = ~clk;

    // d0: LOAD_STALL=1, zero reg excluded, 4-bit counters
    fwd_hazard_unit #(.ADDR_W(5), .LOAD_STALL(1), .ZERO_REG_EN(1), .CNT_W(4)) d0 (
        .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .rt_used_id(rt_used_id),
        .wr_addr_ex(wr_addr_ex), .wr_en_ex(wr_en_ex), .mem_read_ex(mem_read_ex),
        .wr_addr_mem(wr_addr_mem), .wr_en_mem(wr_en_mem), .flush(flush),
        .upper_sel(up_o[0]), .lower_sel(lo_o[0]), .stall(st_o[0]),
        .fwd_count(fc0), .stall_count(sc0));

    // d1: LOAD_STALL=1, zero reg treated like any other
    fwd_hazard_unit #(.ADDR_W(5), .LOAD_STALL(1), .ZERO_REG_EN(0), .CNT_W(16)) d1 (
        .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .rt_used_id(rt_used_id),
        .wr_addr_ex(wr_addr_ex), .wr_en_ex(wr_en_ex), .mem_read_ex(mem_read_ex),
        .wr_addr_mem(wr_addr_mem), .wr_en_mem(wr_en_mem), .flush(flush),
        .upper_sel(up_o[1]), .lower_sel(lo_o[1]), .stall(st_o[1]),
        .fwd_count(fc1), .stall_count(sc1));

    // d2: two bubbles per load-use
    fwd_hazard_unit #(.ADDR_W(5), .LOAD_STALL(2), .ZERO_REG_EN(1), .CNT_W(16)) d2 (
        .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .rt_used_id(rt_used_id),
        .wr_addr_ex(wr_addr_ex), .wr_en_ex(wr_en_ex), .mem_read_ex(mem_read_ex),
        .wr_addr_mem(wr_addr_mem), .wr_en_mem(wr_en_mem), .flush(flush),
        .upper_sel(up_o[2]), .lower_sel(lo_o[2]), .stall(st_o[2]),
        .fwd_count(fc2), .stall_count(sc2));

    int          ls_p [3] = '{1, 1, 2};
    int          zr_p [3] = '{1, 0, 1};
    logic [15:0] cmax [3] = '{16'h000F, 16'hFFFF, 16'hFFFF};

    int          m_rem [3] = '{-1, -1, -1};
    logic [1:0]  m_up  [3];
    logic [1:0]  m_lo  [3];
    logic [15:0] m_fc  [3];
    logic [15:0] m_sc  [3];

    typedef struct packed {
        logic [2:0][1:0]  up;
        logic [2:0][1:0]  lo;
        logic [2:0][15:0] fc;
        logic [2:0][15:0] sc;
    } exp_t;
    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic mt(input logic en, input logic [4:0] w, input logic [4:0] a,
                                input int zr);
        return en && (w == a) && !(zr != 0 && a == 5'd0);
    endfunction

    function automatic logic [15:0] get_fc(input int i);
        case (i)
            0:       return {12'd0, fc0};
            1:       return fc1;
            default: return fc2;
        endcase
    endfunction

    function automatic logic [15:0] get_sc(input int i);
        case (i)
            0:       return {12'd0, sc0};
            1:       return sc1;
            default: return sc2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rtu, input logic [4:0] wx, input logic wex,
                        input logic mrx, input logic [4:0] wm, input logic wem,
                        input logic fl);
        exp_t e;
        exp_t g;
        logic ex_rs, ex_rt, mm_rs, mm_rt, det, stl;
        logic [1:0] nu, nl;
        rst_n = r; rs_id = rs; rt_id = rt; rt_used_id = rtu;
        wr_addr_ex = wx; wr_en_ex = wex; mem_read_ex = mrx;
        wr_addr_mem = wm; wr_en_mem = wem; flush = fl;
        #1;
        for (int i = 0; i < 3; i++) begin
            ex_rs = mt(wex, wx, rs, zr_p[i]);
            ex_rt = rtu && mt(wex, wx, rt, zr_p[i]);
            mm_rs = mt(wem, wm, rs, zr_p[i]);
            mm_rt = rtu && mt(wem, wm, rt, zr_p[i]);
            det   = (m_rem[i] == 0) && !fl && mrx && (ex_rs || ex_rt);
            stl   = !fl && (det || (m_rem[i] > 0));
            nu    = (fl || stl) ? 2'd0 : (ex_rs && !mrx) ? 2'd2 : mm_rs ? 2'd1 : 2'd0;
            nl    = (fl || stl) ? 2'd0 : (ex_rt && !mrx) ? 2'd2 : mm_rt ? 2'd1 : 2'd0;
            if (m_rem[i] >= 0)
                chk($sformatf("d%0d.stall", i), {15'd0, st_o[i]}, {15'd0, stl});
            if (!r) begin
                m_rem[i] = 0; m_up[i] = 0; m_lo[i] = 0; m_fc[i] = 0; m_sc[i] = 0;
            end else begin
                m_rem[i] = fl ? 0 : det ? ls_p[i] - 1 : (m_rem[i] > 0) ? m_rem[i] - 1 : 0;
                if ((nu != 0 || nl != 0) && m_fc[i] != cmax[i]) m_fc[i] = m_fc[i] + 1;
                if (stl && m_sc[i] != cmax[i]) m_sc[i] = m_sc[i] + 1;
                m_up[i] = nu;
                m_lo[i] = nl;
            end
            e.up[i] = m_up[i]; e.lo[i] = m_lo[i]; e.fc[i] = m_fc[i]; e.sc[i] = m_sc[i];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d.upper_sel", i), {14'd0, up_o[i]}, {14'd0, g.up[i]});
            chk($sformatf("d%0d.lower_sel", i), {14'd0, lo_o[i]}, {14'd0, g.lo[i]});
            chk($sformatf("d%0d.fwd_count", i), get_fc(i), g.fc[i]);
            chk($sformatf("d%0d.stall_count", i), get_sc(i), g.sc[i]);
        end
    endtask

    task automatic rnd_step(input logic r);
        step(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 5) == 0));
    endtask

    logic [15:0] sc_before;

    initial begin
        rst_n = 1'b0; flush = 1'b0; rt_used_id = 1'b0; wr_en_ex = 1'b0;
        mem_read_ex = 1'b0; wr_en_mem = 1'b0;
        rs_id = '0; rt_id = '0; wr_addr_ex = '0; wr_addr_mem = '0;
        @(posedge clk);
        #1;
        // reset with random inputs, then release with no matches
        rnd_step(1'b0);
        rnd_step(1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d.reset_fwd", i), get_fc(i), 16'd0);
            chk($sformatf("d%0d.reset_upper", i), {14'd0, up_o[i]}, 16'd0);
        end
        //    r  rs  rt  rtu wx  wex mrx wm  wem fl
        step(1, 1,  2,  1,  5,  1,  0,  6,  1,  0);
        // ALU-ALU: EX only, MEM only, both (EX wins)
        step(1, 8,  0,  0,  8,  1,  0,  0,  0,  0);
        step(1, 8,  0,  0,  0,  0,  0,  8,  1,  0);
        step(1, 8,  0,  0,  8,  1,  0,  8,  1,  0);
        // rt lane, with and without rt_used_id
        step(1, 1,  3,  1,  0,  0,  0,  3,  1,  0);
        step(1, 1,  3,  0,  3,  1,  0,  3,  1,  0);
        step(1, 4,  4,  1,  4,  1,  0,  0,  0,  0);
        // write enable gates matching
        step(1, 7,  7,  1,  7,  0,  0,  7,  0,  0);
        // zero register load: only d1 stalls
        step(1, 0,  0,  1,  0,  1,  1,  0,  1,  0);
        step(1, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        // load-use on rt, then the load moves to MEM
        step(1, 1,  9,  1,  9,  1,  1,  0,  0,  0);
        step(1, 1,  9,  1,  2,  1,  0,  9,  1,  0);
        step(1, 1,  9,  1,  0,  0,  0,  0,  0,  0);
        step(1, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        // load-use with flush in the second stall cycle
        step(1, 9,  0,  0,  9,  1,  1,  0,  0,  0);
        step(1, 9,  0,  0,  0,  0,  0,  9,  1,  1);
        step(1, 9,  0,  0,  0,  0,  0,  0,  0,  0);
        // load-use without flush: d2 stalls two cycles
        sc_before = sc2;
        step(1, 9,  0,  0,  9,  1,  1,  0,  0,  0);
        step(1, 9,  0,  0,  0,  0,  0,  9,  1,  0);
        step(1, 9,  0,  0,  0,  0,  0,  0,  0,  0);
        chk("d2.stall_len", sc2 - sc_before, 16'd2);
        // flush on the detection cycle suppresses the stall
        step(1, 9,  0,  0,  9,  1,  1,  0,  0,  1);
        // reset in the middle of a d2 stall
        step(1, 9,  0,  0,  9,  1,  1,  0,  0,  0);
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        step(1, 0,  0,  0,  0,  0,  0,  0,  0,  0);
        // 20 back-to-back forwards: d0's 4-bit counter saturates
        for (int k = 0; k < 20; k++)
            step(1, 8, 0, 0, 8, 1, 0, 0, 0, 0);
        chk("d0.fwd_sat", {12'd0, fc0}, 16'd15);
        for (int k = 0; k < 40; k++)
            rnd_step(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
